// File: rtl/uarch_pkg.sv
// Shared micro-architecture parameters and payload types for the out-of-order core.
package uarch_pkg;
  localparam int unsigned PIPE_WIDTH = 2;
  localparam int unsigned TAG_WIDTH  = 4;
  localparam int unsigned ROB_DEPTH  = 1 << TAG_WIDTH;
  localparam int unsigned CDB_PORTS  = 2;
  localparam int unsigned AREG_W     = 5;
  localparam int unsigned XLEN       = 32;

  typedef struct packed {
    logic                 we;
    logic [AREG_W-1:0]    addr;
    logic [TAG_WIDTH-1:0] tag;
    logic [XLEN-1:0]      data;
  } prf_commit_write_port_t;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              has_rd;
    logic [AREG_W-1:0] rd;
    logic [XLEN-1:0]   data;
  } rob_entry_t;

  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction
endpackage

// File: rtl/rob.sv
// Reorder buffer: 2-wide allocation from rename, CDB completion, 2-wide in-order retirement.
module rob
  import uarch_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic [PIPE_WIDTH-1:0]                  rob_alloc_req,
  input  logic [PIPE_WIDTH-1:0][AREG_W-1:0]      rob_alloc_rd,
  input  logic [PIPE_WIDTH-1:0]                  rob_alloc_has_rd,
  input  logic                                   rob_alloc_fire,
  output logic [PIPE_WIDTH-1:0]                  rob_alloc_gnt,
  output logic [PIPE_WIDTH-1:0][TAG_WIDTH-1:0]   rob_alloc_tags,
  input  logic [CDB_PORTS-1:0]                   cdb_valid,
  input  logic [CDB_PORTS-1:0][TAG_WIDTH-1:0]    cdb_tag,
  input  logic [CDB_PORTS-1:0][XLEN-1:0]         cdb_data,
  output prf_commit_write_port_t [PIPE_WIDTH-1:0] commit_write_ports,
  output logic                                   rob_empty,
  output logic                                   rob_full
);
  localparam int unsigned CNT_W = TAG_WIDTH + 1;

  rob_entry_t           entries_q [ROB_DEPTH];
  rob_entry_t           entries_d [ROB_DEPTH];
  logic [TAG_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic                 kill;
  logic [CNT_W-1:0]     free_slots;
  logic [1:0]           n_req, n_alloc, n_commit;
  logic [TAG_WIDTH-1:0] head_p1;
  logic                 c0, c1;

  assign kill       = rst | flush;
  assign free_slots = CNT_W'(ROB_DEPTH) - count_q;
  assign n_req      = popcount2(rob_alloc_req);
  assign head_p1    = head_q + TAG_WIDTH'(1);
  assign rob_empty  = (count_q == '0);
  assign rob_full   = (count_q == CNT_W'(ROB_DEPTH));

  // Grant sees only registered occupancy so rename_rdy never loops back through it.
  always_comb begin
    rob_alloc_gnt     = '0;
    rob_alloc_tags[0] = tail_q;
    rob_alloc_tags[1] = rob_alloc_req[0] ? tail_q + TAG_WIDTH'(1) : tail_q;
    if (!kill && (free_slots >= CNT_W'(n_req))) rob_alloc_gnt = rob_alloc_req;
  end

  // Retirement select: slot 1 only follows a retiring slot 0.
  always_comb begin
    c0 = entries_q[head_q].valid && entries_q[head_q].done;
    c1 = c0 && entries_q[head_p1].valid && entries_q[head_p1].done;
    commit_write_ports[0].we   = c0 && entries_q[head_q].has_rd && !kill;
    commit_write_ports[0].addr = entries_q[head_q].rd;
    commit_write_ports[0].tag  = head_q;
    commit_write_ports[0].data = entries_q[head_q].data;
    commit_write_ports[1].we   = c1 && entries_q[head_p1].has_rd && !kill;
    commit_write_ports[1].addr = entries_q[head_p1].rd;
    commit_write_ports[1].tag  = head_p1;
    commit_write_ports[1].data = entries_q[head_p1].data;
    n_commit = {1'b0, c0} + {1'b0, c1};
  end

  always_comb begin
    entries_d = entries_q;
    n_alloc   = rob_alloc_fire ? popcount2(rob_alloc_gnt) : 2'd0;

    // Higher port applied first so port 0 overrides on a shared tag.
    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
      if (cdb_valid[p] && entries_q[cdb_tag[p]].valid) begin
        entries_d[cdb_tag[p]].done = 1'b1;
        entries_d[cdb_tag[p]].data = cdb_data[p];
      end
    end

    if (c0) entries_d[head_q].valid  = 1'b0;
    if (c1) entries_d[head_p1].valid = 1'b0;

    for (int i = 0; i < PIPE_WIDTH; i++) begin
      if (rob_alloc_fire && rob_alloc_gnt[i]) begin
        entries_d[rob_alloc_tags[i]] = '{valid: 1'b1, done: 1'b0,
                                         has_rd: rob_alloc_has_rd[i],
                                         rd: rob_alloc_rd[i], data: '0};
      end
    end

    head_d  = head_q + TAG_WIDTH'(n_commit);
    tail_d  = tail_q + TAG_WIDTH'(n_alloc);
    count_d = count_q + CNT_W'(n_alloc) - CNT_W'(n_commit);

    if (flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries_d[i].valid = 1'b0;
        entries_d[i].done  = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) entries_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < ROB_DEPTH; i++) entries_q[i] <= entries_d[i];
    end
  end
endmodule

// File: tb/tb_rob.sv
// Directed bench for the reorder buffer: grant, ordered retirement, wrap and flush.
module tb_rob;
  import uarch_pkg::*;

  logic clk = 1'b0;
  logic rst, flush, fire;
  logic [1:0] req, has_rd, gnt, cdb_valid;
  logic [1:0][4:0] rd;
  logic [1:0][3:0] tags, cdb_tag;
  logic [1:0][31:0] cdb_data;
  prf_commit_write_port_t [1:0] cwp;
  logic empty, full;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rob dut (
    .clk(clk), .rst(rst), .flush(flush),
    .rob_alloc_req(req), .rob_alloc_rd(rd), .rob_alloc_has_rd(has_rd),
    .rob_alloc_fire(fire), .rob_alloc_gnt(gnt), .rob_alloc_tags(tags),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .commit_write_ports(cwp), .rob_empty(empty), .rob_full(full)
  );

  task automatic idle();
    flush = 0; fire = 0; req = 0; has_rd = 0; rd = '0;
    cdb_valid = 0; cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic test_reset();
    rst = 1; idle(); req = 2'b11;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags: got empty=%b full=%b want 1/0", empty, full); end
    checks++; if (cwp[0].we !== 1'b0 || cwp[1].we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b%b want 00", cwp[1].we, cwp[0].we); end
  endtask

  task automatic test_alloc();
    @(negedge clk); rst = 0; idle(); req = 2'b11; #1;
    checks++; if (gnt !== 2'b11 || tags[0] !== 4'd0 || tags[1] !== 4'd1) begin errors++; $display("FAIL alloc_gnt: got gnt=%b tags=%0d/%0d want 11 0/1", gnt, tags[0], tags[1]); end
    @(negedge clk); #1;
    checks++; if (empty !== 1'b1 || tags[0] !== 4'd0) begin errors++; $display("FAIL alloc_nofire: got empty=%b tail=%0d want 1 0", empty, tags[0]); end
    fire = 1; rd[0] = 5'd1; rd[1] = 5'd2;
    @(negedge clk); idle(); #1;
    checks++; if (empty !== 1'b0 || tags[0] !== 4'd2) begin errors++; $display("FAIL alloc_count: got empty=%b tail=%0d want 0 2", empty, tags[0]); end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); idle(); req = 2'b11; fire = 1;
    end
    @(negedge clk); idle(); req = 2'b11; #1;
    checks++; if (gnt !== 2'b11) begin errors++; $display("FAIL fill_14: got %b want 11", gnt); end
    req = 2'b01; fire = 1;
    @(negedge clk); idle(); req = 2'b11; #1;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL fill_15_pair: got %b want 00", gnt); end
    req = 2'b01; #1;
    checks++; if (gnt !== 2'b01 || full !== 1'b0) begin errors++; $display("FAIL fill_15_single: got gnt=%b full=%b want 01 0", gnt, full); end
    fire = 1;
    @(negedge clk); idle(); req = 2'b11; #1;
    checks++; if (full !== 1'b1 || gnt !== 2'b00) begin errors++; $display("FAIL fill_full: got full=%b gnt=%b want 1 00", full, gnt); end
    req = 2'b01; #1;
    checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL fill_full_single: got %b want 00", gnt); end
    req = 2'b00; flush = 1;
    @(negedge clk); idle(); #1;
    checks++; if (empty !== 1'b1 || tags[0] !== 4'd0) begin errors++; $display("FAIL fill_flush: got empty=%b tail=%0d want 1 0", empty, tags[0]); end
  endtask

  task automatic test_ordered_commit();
    idle(); req = 2'b11; fire = 1; has_rd = 2'b11; rd[0] = 5'd5; rd[1] = 5'd6;
    @(negedge clk); idle(); cdb_valid = 2'b01; cdb_tag[0] = 4'd1; cdb_data[0] = 32'hBEEF; #1;
    checks++; if (cwp[0].we !== 1'b0) begin errors++; $display("FAIL order_none: got we0=%b want 0", cwp[0].we); end
    @(negedge clk); idle(); cdb_valid = 2'b10; cdb_tag[1] = 4'd0; cdb_data[1] = 32'h1234; #1;
    checks++; if (cwp[0].we !== 1'b0 || cwp[1].we !== 1'b0) begin errors++; $display("FAIL order_wait: got we=%b%b want 00", cwp[1].we, cwp[0].we); end
    @(negedge clk); idle(); #1;
    checks++; if (cwp[0] !== '{1'b1, 5'd5, 4'd0, 32'h1234}) begin errors++; $display("FAIL order_port0: got we=%b addr=%0d tag=%0d data=%h want 1 5 0 1234", cwp[0].we, cwp[0].addr, cwp[0].tag, cwp[0].data); end
    checks++; if (cwp[1] !== '{1'b1, 5'd6, 4'd1, 32'hBEEF}) begin errors++; $display("FAIL order_port1: got we=%b addr=%0d tag=%0d data=%h want 1 6 1 beef", cwp[1].we, cwp[1].addr, cwp[1].tag, cwp[1].data); end
    @(negedge clk); #1;
    checks++; if (empty !== 1'b1 || tags[0] !== 4'd2) begin errors++; $display("FAIL order_drain: got empty=%b tail=%0d want 1 2", empty, tags[0]); end
  endtask

  task automatic test_no_rd();
    idle(); req = 2'b11; fire = 1; has_rd = 2'b10; rd[0] = 5'd7; rd[1] = 5'd9;
    @(negedge clk); idle(); cdb_valid = 2'b01; cdb_tag[0] = 4'd2; cdb_data[0] = 32'h11;
    @(negedge clk); idle(); #1;
    checks++; if (cwp[0].we !== 1'b0 || cwp[0].tag !== 4'd2 || cwp[1].we !== 1'b0) begin errors++; $display("FAIL nord_commit: got we=%b%b tag=%0d want 00 2", cwp[1].we, cwp[0].we, cwp[0].tag); end
    @(negedge clk); idle(); cdb_valid = 2'b11; cdb_tag[0] = 4'd3; cdb_tag[1] = 4'd3;
    cdb_data[0] = 32'h55; cdb_data[1] = 32'h66; #1;
    checks++; if (cwp[0].tag !== 4'd3 || cwp[0].we !== 1'b0) begin errors++; $display("FAIL nord_head: got tag=%0d we=%b want 3 0", cwp[0].tag, cwp[0].we); end
    @(negedge clk); idle(); #1;
    checks++; if (cwp[0] !== '{1'b1, 5'd9, 4'd3, 32'h55}) begin errors++; $display("FAIL nord_next: got we=%b addr=%0d tag=%0d data=%h want 1 9 3 55", cwp[0].we, cwp[0].addr, cwp[0].tag, cwp[0].data); end
    @(negedge clk); #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL nord_drain: got empty=%b want 1", empty); end
  endtask

  task automatic test_wrap();
    @(negedge clk); idle(); flush = 1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk); idle();
      if (k < 8) begin fire = 1; req = (k == 0) ? 2'b01 : 2'b11; end
      if (k == 1) begin
        cdb_valid = 2'b01; cdb_tag[0] = 4'd0;
      end else if (k >= 2) begin
        cdb_valid = 2'b11; cdb_tag[0] = 4'(2 * k - 3); cdb_tag[1] = 4'(2 * k - 2);
      end
    end
    repeat (3) @(negedge clk);
    idle(); #1;
    checks++; if (empty !== 1'b1 || tags[0] !== 4'd15) begin errors++; $display("FAIL wrap_pre: got empty=%b tail=%0d want 1 15", empty, tags[0]); end
    req = 2'b11; fire = 1; has_rd = 2'b11; rd[0] = 5'd3; rd[1] = 5'd4; #1;
    checks++; if (gnt !== 2'b11 || tags[0] !== 4'd15 || tags[1] !== 4'd0) begin errors++; $display("FAIL wrap_tags: got gnt=%b tags=%0d/%0d want 11 15/0", gnt, tags[0], tags[1]); end
    @(negedge clk); idle(); cdb_valid = 2'b11; cdb_tag[0] = 4'd0; cdb_data[0] = 32'hA0;
    cdb_tag[1] = 4'd15; cdb_data[1] = 32'hF0;
    @(negedge clk); idle(); #1;
    checks++; if (cwp[0] !== '{1'b1, 5'd3, 4'd15, 32'hF0}) begin errors++; $display("FAIL wrap_port0: got we=%b addr=%0d tag=%0d data=%h want 1 3 15 f0", cwp[0].we, cwp[0].addr, cwp[0].tag, cwp[0].data); end
    checks++; if (cwp[1] !== '{1'b1, 5'd4, 4'd0, 32'hA0}) begin errors++; $display("FAIL wrap_port1: got we=%b addr=%0d tag=%0d data=%h want 1 4 0 a0", cwp[1].we, cwp[1].addr, cwp[1].tag, cwp[1].data); end
    @(negedge clk); #1;
    checks++; if (empty !== 1'b1 || tags[0] !== 4'd1) begin errors++; $display("FAIL wrap_drain: got empty=%b tail=%0d want 1 1", empty, tags[0]); end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); idle(); req = 2'b11; fire = 1; has_rd = 2'b11; rd[0] = 5'(k + 10); rd[1] = 5'(k + 20);
    end
    @(negedge clk); idle(); cdb_valid = 2'b11; cdb_tag[0] = 4'd1; cdb_tag[1] = 4'd2;
    cdb_data[0] = 32'hAA; cdb_data[1] = 32'hBB;
    @(negedge clk); idle(); #1;
    checks++; if (cwp[0].we !== 1'b1 || cwp[1].we !== 1'b1) begin errors++; $display("FAIL flush_pre: got we=%b%b want 11", cwp[1].we, cwp[0].we); end
    flush = 1; req = 2'b11; #1;
    checks++; if (cwp[0].we !== 1'b0 || cwp[1].we !== 1'b0 || gnt !== 2'b00) begin errors++; $display("FAIL flush_cycle: got we=%b%b gnt=%b want 00 00", cwp[1].we, cwp[0].we, gnt); end
    @(negedge clk); idle(); cdb_valid = 2'b11; cdb_tag[0] = 4'd0; cdb_tag[1] = 4'd3; cdb_data = '1; #1;
    checks++; if (empty !== 1'b1 || tags[0] !== 4'd0 || cwp[0].tag !== 4'd0) begin errors++; $display("FAIL flush_ptrs: got empty=%b tail=%0d head=%0d want 1 0 0", empty, tags[0], cwp[0].tag); end
    @(negedge clk); idle(); #1;
    checks++; if (empty !== 1'b1 || cwp[0].we !== 1'b0 || cwp[1].we !== 1'b0) begin errors++; $display("FAIL flush_stale_cdb: got empty=%b we=%b%b want 1 00", empty, cwp[1].we, cwp[0].we); end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_fill();
    test_ordered_commit();
    test_no_rd();
    test_wrap();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rob.md
Name: rob

Overview:
- Reorder buffer: a circular buffer of in-flight instructions, 2-wide allocation and 2-wide in-order retirement.
- Acts as the responder to the rename stage's allocation handshake (rob_alloc_req / rob_alloc_gnt / rob_alloc_tags).
- Collects results from the CDB.
- Retires completed head entries by driving commit_write_ports into the PRF, which clears speculative mappings and writes architectural data.

Parameters:
PIPE_WIDTH, 2 (uarch_pkg), allocation and commit width; logic is written for exactly 2.
TAG_WIDTH, uarch_pkg value, ROB tag width; ROB_DEPTH = 2**TAG_WIDTH entries.
CDB_PORTS, 2, number of writeback broadcast ports.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
flush  in  1  pipeline flush; synchronous, empties the ROB
rob_alloc_req  in  PIPE_WIDTH  per-slot allocation request from rename
rob_alloc_rd  in  5 x PIPE_WIDTH  architectural rd per slot
rob_alloc_has_rd  in  PIPE_WIDTH  slot writes rd
rob_alloc_fire  in  1  rename advances this cycle (rename_rdy); allocation takes effect only when high
rob_alloc_gnt  out  PIPE_WIDTH  per-slot grant
rob_alloc_tags  out  TAG_WIDTH x PIPE_WIDTH  tags for slot 0/1
cdb_valid  in  CDB_PORTS  writeback valid
cdb_tag  in  TAG_WIDTH x CDB_PORTS  completing tag
cdb_data  in  32 x CDB_PORTS  result value
commit_write_ports  out  prf_commit_write_port_t x PIPE_WIDTH  {we, addr, tag, data} to the PRF
rob_empty  out  1  count == 0
rob_full  out  1  count == ROB_DEPTH

Behaviour:
- State:
  - entry array of rob_entry_t {valid, done, has_rd, rd, data};
  - head, tail (TAG_WIDTH bits, wrap modulo ROB_DEPTH);
  - count (TAG_WIDTH+1 bits).
- Reset or flush (priority over all other updates), applied at the clock edge:
  - all entry.valid/done = 0; head = tail = 0; count = 0.
  - While rst or flush is high, commit_write_ports.we = 0 and rob_alloc_gnt = 0.
- Grant is combinational, computed from registered count only; it must not depend on rob_alloc_fire (avoids a loop through rename_rdy).
  - n_req = popcount(rob_alloc_req).
  - gnt = rob_alloc_req if (ROB_DEPTH - count) >= n_req, else 0 (all-or-nothing).
  - tags[0] = tail; tags[1] = rob_alloc_req[0] ? tail+1 : tail. Tags are driven even when gnt = 0.
- Allocation at the edge when rob_alloc_fire && gnt[i]:
  - entry[tag_i] = {valid=1, done=0, rd, has_rd, data=0}.
  - tail += popcount(gnt).
  - No allocation when fire is low, even if granted.
- Writeback:
  - cdb_valid[p] && entry[cdb_tag[p]].valid sets done = 1 and data = cdb_data[p].
  - Writeback to an invalid entry is ignored.
  - Same tag on two ports: the lower port index wins.
- Commit is combinational from registered state:
  - c0 = entry[head].valid && done.
  - c1 = c0 && entry[head+1].valid && done (strictly in order; slot 1 never commits alone).
  - Port i: we = c_i && has_rd; addr = rd; tag = head+i; data = entry data.
  - A committing entry without rd still retires, with we = 0.
- Commit update at the edge: committed entries valid = 0; head += n_commit.
- Count: count_next = count + n_alloc - n_commit.
  - Entries freed by a commit are not grantable in the same cycle.
- Latency:
  - CDB at cycle N → commit port visible at N+1 at the earliest.
  - Alloc at N → entry eligible for writeback from N+1.

Decomposition:
- uarch_pkg gains:
  - ROB_DEPTH localparam;
  - rob_entry_t typedef.
- prf_commit_write_port_t already exists in uarch_pkg and is reused.
- No sub-module: grant, commit-select and pointer logic stay in one module, about 200 lines.

Test Plan:
- Reset, then req=2'b11, fire=1 → gnt=11, tags 0/1; next cycle count=2, rob_empty=0.
- Fill to ROB_DEPTH with fire each cycle → rob_full=1; further req=11 → gnt=00; with count=ROB_DEPTH-1, req=11 → gnt=00, req=01 → gnt=01.
- Alloc tags 0,1 (rd=5,6); CDB writes tag1=0xBEEF, then tag0=0x1234 one cycle later → no commit until tag0 is done; then both retire the same cycle:
  - port0 {we=1, addr=5, tag=0, data=0x1234};
  - port1 {we=1, addr=6, tag=1, data=0xBEEF}.
- Head entry with has_rd=0 completes → commits with we=0, head advances by 1.
- Wrap-around: pointers near ROB_DEPTH-1, allocate 2 → tags ROB_DEPTH-1 and 0; commit across the wrap in order.
- Flush with 10 entries, some done → next cycle count=0, head=tail=0, no commit we asserted in the flush cycle; a CDB write to an old tag after the flush is ignored.
